sram_ctrl: RTL and testbench

- Memory-side responder for the CPU memory stage. Drives the board's 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two 16-bit half-word accesses: low half first, then high half.
- Holds `ready` low while busy so the pipeline stalls, then returns read data.
- Instantiated in the board top between Top's memory request interface and the SRAM_* pins.

---
 rtl/sram_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: CPU memory-stage responder for a 16-bit async SRAM.
// Splits each 32-bit access into low then high half-word cycles.
// Ports: clk, rst (async, active-low), wr_en/rd_en/address/write_data
//   request, read_data/ready response, SRAM_* board pins.
// Optional: define SRAM_CTRL_STATS_EN to add rd_count/wr_count outputs.
module sram_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_WAIT, S_DONE
    } state_t;

    localparam logic [15:0] WAIT_N = 16'(ACCESS_CYCLES - 4);

    state_t      state, nxt;
    logic        op_wr;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic [16:0] word_d;
    logic        req;

    // (addr - base) mod 2^19, then drop the byte offset.
    assign word_d = 17'((address - BASE_ADDR) >> 2);
    assign req    = wr_en | rd_en;
    assign ready  = ~req | (state == S_DONE);

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;

    // State register plus datapath captures.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_wr     <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            read_data <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req) begin
                op_wr   <= wr_en;
                word_q  <= word_d;
                wdata_q <= write_data;
            end
            if (state == S_LO && !op_wr)
                read_data[15:0] <= SRAM_DQ;
            if (state == S_HI && !op_wr)
                read_data[31:16] <= SRAM_DQ;
            if (state == S_HI)
                cnt <= WAIT_N;
            else if (state == S_WAIT)
                cnt <= cnt - 16'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (req) nxt = S_LO;
            S_LO:   nxt = S_HI;
            S_HI:   nxt = (WAIT_N == 16'd0) ? S_DONE : S_WAIT;
            S_WAIT: if (cnt <= 16'd1) nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Pin outputs; idle/reset presents address 0 with output enabled.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        unique case (state)
            S_LO: begin
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~op_wr;
                SRAM_OE_N = op_wr;
                dq_oe     = op_wr;
                dq_out    = wdata_q[15:0];
            end
            S_HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~op_wr;
                SRAM_OE_N = op_wr;
                dq_oe     = op_wr;
                dq_out    = wdata_q[31:16];
            end
            default: ;
        endcase
    end

`ifdef SRAM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == S_DONE) begin
            if (op_wr && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (!op_wr && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with behavioural SRAMs.
// Runs a default instance (6 cycles) and a 4-cycle instance.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        use4 = 1'b0;

    int errs = 0;
    int checks = 0;

    logic        wr6, rd6, wr4, rd4;
    logic [31:0] rdata6, rdata4;
    logic        ready6, ready4;
    wire  [15:0] dq6, dq4;
    logic [17:0] addr6, addr4;
    logic        ub6, lb6, ce6, we6, oe6;
    logic        ub4, lb4, ce4, we4, oe4;
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rdc6, wrc6, rdc4, wrc4;
`endif

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    int we_lo6 = 0;

    assign wr6 = wr_en & ~use4;
    assign rd6 = rd_en & ~use4;
    assign wr4 = wr_en & use4;
    assign rd4 = rd_en & use4;

    always #5 clk = ~clk;

    sram_ctrl u6 (
        .clk(clk), .rst(rst), .wr_en(wr6), .rd_en(rd6),
        .address(address), .write_data(write_data),
        .read_data(rdata6), .ready(ready6), .SRAM_DQ(dq6),
        .SRAM_ADDR(addr6), .SRAM_UB_N(ub6), .SRAM_LB_N(lb6),
        .SRAM_CE_N(ce6), .SRAM_WE_N(we6), .SRAM_OE_N(oe6)
`ifdef SRAM_CTRL_STATS_EN
        , .rd_count(rdc6), .wr_count(wrc6)
`endif
    );

    sram_ctrl #(.ACCESS_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .wr_en(wr4), .rd_en(rd4),
        .address(address), .write_data(write_data),
        .read_data(rdata4), .ready(ready4), .SRAM_DQ(dq4),
        .SRAM_ADDR(addr4), .SRAM_UB_N(ub4), .SRAM_LB_N(lb4),
        .SRAM_CE_N(ce4), .SRAM_WE_N(we4), .SRAM_OE_N(oe4)
`ifdef SRAM_CTRL_STATS_EN
        , .rd_count(rdc4), .wr_count(wrc4)
`endif
    );

    // Async SRAM models: drive on read, store while WE_N is low.
    assign dq6 = (!oe6 && we6) ? mem0[addr6] : 16'bz;
    assign dq4 = (!oe4 && we4) ? mem1[addr4] : 16'bz;

    always @(posedge clk) begin
        if (!we6) begin
            mem0[addr6] <= dq6;
            we_lo6 <= we_lo6 + 1;
        end
        if (!we4)
            mem1[addr4] <= dq4;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue a request, count cycles to ready, drop it after DONE.
    task automatic xact(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat);
        wr_en = w;
        rd_en = r;
        address = a;
        write_data = d;
        #1;
        lat = 0;
        while (!(use4 ? ready4 : ready6) && lat < 30) begin
            @(posedge clk);
            #2;
            lat++;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int lat;
        int w0;
        logic [31:0] e;

        for (int i = 0; i < 20; i++)
            mem1[i] = 16'hA000 + 16'(i);

        #3;
        chk("rst_ready", {31'd0, ready6}, 32'd1);
        chk("rst_we", {31'd0, we6}, 32'd1);
        chk("rst_oe", {31'd0, oe6}, 32'd0);
        chk("rst_addr", {14'd0, addr6}, 32'd0);
        chk("rst_rdata", rdata6, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        xact(1, 0, 32'd1024, 32'hDEADBEEF, lat);
        chk("wr_lat", lat, 32'd5);
        chk("wr_lo", {16'd0, mem0[0]}, 32'h0000BEEF);
        chk("wr_hi", {16'd0, mem0[1]}, 32'h0000DEAD);

        xact(0, 1, 32'd1024, 32'h0, lat);
        chk("rd_lat", lat, 32'd5);
        chk("rd_data", rdata6, 32'hDEADBEEF);

        xact(1, 0, 32'd1032, 32'h76543210, lat);
        chk("map_lo", {16'd0, mem0[4]}, 32'h00003210);
        chk("map_hi", {16'd0, mem0[5]}, 32'h00007654);

        xact(1, 0, 32'd0, 32'h0BADCAFE, lat);
        chk("wrap_lo", {16'd0, mem0[18'h3FE00]}, 32'h0000CAFE);
        chk("wrap_hi", {16'd0, mem0[18'h3FE01]}, 32'h00000BAD);

        w0 = we_lo6;
        xact(1, 1, 32'd1056, 32'h12345678, lat);
        chk("both_we", we_lo6 - w0, 32'd2);
        chk("both_lo", {16'd0, mem0[16]}, 32'h00005678);
        chk("both_hi", {16'd0, mem0[17]}, 32'h00001234);

        // Request withdrawn after one cycle: both halves still land.
        wr_en = 1'b1;
        address = 32'd1040;
        write_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("drop_lo", {16'd0, mem0[8]}, 32'h0000F00D);
        chk("drop_hi", {16'd0, mem0[9]}, 32'h0000CAFE);
        xact(0, 1, 32'd1040, 32'h0, lat);
        chk("drop_rd", rdata6, 32'hCAFEF00D);

        // Reset in the HI cycle of a write.
        wr_en = 1'b1;
        address = 32'd1048;
        write_data = 32'h11112222;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        chk("hi_we", {31'd0, we6}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_we", {31'd0, we6}, 32'd1);
        chk("mid_oe", {31'd0, oe6}, 32'd0);
        chk("mid_addr", {14'd0, addr6}, 32'd0);
        chk("mid_rdata", rdata6, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("mid_ready", {31'd0, ready6}, 32'd1);
`ifdef SRAM_CTRL_STATS_EN
        chk("rst_wrc", {16'd0, wrc6}, 32'd0);
        chk("rst_rdc", {16'd0, rdc6}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        xact(0, 1, 32'd1024, 32'h0, lat);
        chk("post_lat", lat, 32'd5);
        chk("post_rd", rdata6, 32'hDEADBEEF);

        xact(1, 0, 32'd1100, 32'h00000001, lat);
        xact(1, 0, 32'd1104, 32'h00000002, lat);
        xact(1, 0, 32'd1108, 32'h00000003, lat);
        xact(0, 1, 32'd1104, 32'h0, lat);
        chk("st_rd", rdata6, 32'h00000002);
`ifdef SRAM_CTRL_STATS_EN
        chk("st_wrc", {16'd0, wrc6}, 32'd3);
        chk("st_rdc", {16'd0, rdc6}, 32'd2);
`endif

        // Short-latency instance, back-to-back reads.
        use4 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            xact(0, 1, 32'd1024 + 32'(4 * k), 32'h0, lat);
            e = {16'hA000 + 16'(2 * k + 1), 16'hA000 + 16'(2 * k)};
            chk($sformatf("sw_lat%0d", k), lat, 32'd3);
            chk($sformatf("sw_rd%0d", k), rdata4, e);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
